// File: rtl/reg_file_mp_if.sv
// Register-file port bundle: read addresses/data, write port, clear request and status.
// Master drives addresses and write data; slave (the register file) returns data and status.
interface reg_file_mp_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREAD = 2
);
  logic [NREAD*AW-1:0] raddr;
  logic [NREAD*N-1:0]  rdata;
  logic [AW-1:0]       rv;
  logic                regwr;
  logic [N-1:0]        busv;
  logic                clrreq;
  logic                busy;
  logic                wrdrop;

  modport master (
    output raddr, rv, regwr, busv, clrreq,
    input  rdata, busy, wrdrop
  );

  modport slave (
    input  raddr, rv, regwr, busv, clrreq,
    output rdata, busy, wrdrop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired-zero entry 0 and a one-entry-per-cycle clear engine.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int unsigned N     = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREAD = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {StIdle, StClear} state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            busy_q;
  logic            wrdrop_q;
  logic [N-1:0]    mem_q [DEPTH];
  logic            wr_en;
  logic [AW-1:0]   ra;

  assign wr_en = bus.regwr && (state_q == StIdle) && (bus.rv != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wrdrop_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wrdrop_q <= bus.regwr && (state_q == StClear);
      unique case (state_q)
        StIdle: begin
          if (wr_en) mem_q[bus.rv] <= bus.busv;
          // A same-cycle write still lands; the sweep zeroes it later.
          if (bus.clrreq) begin
            state_q <= StClear;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    ra        = '0;
    for (int k = 0; k < int'(NREAD); k++) begin
      ra = bus.raddr[k*AW +: AW];
      if (ra != '0) begin
        bus.rdata[k*N +: N] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (ra == bus.rv)) bus.rdata[k*N +: N] = bus.busv;
`else
`endif
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.wrdrop = wrdrop_q;
endmodule
